// File: rtl/fetch_buf.sv
// fetch_buf: instruction fetch unit with a credit-controlled prefetch queue.
// Issues sequential word reads, buffers returning instructions in FIFO order
// and flushes everything (queue and the read in flight) on a mispredict.
module fetch_buf #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 8,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mispredict,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req,
  output logic [XLEN-1:0]          imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     ready_out,
  output logic                     valid_out,
  output logic [31:0]              instr_out,
  output logic [XLEN-1:0]          pc_out,
  output logic [XLEN-1:0]          pc_4,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count_q;

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [CW:0]     credit_used;
  logic            push;
  logic            pop;

  // Credit rule: only request when every outstanding response is sure to find a slot.
  assign credit_used = {1'b0, count_q} + (CW+1)'(inflight);
  assign imem_req    = !reset && !mispredict && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  // A flush in the same cycle beats both queue operations.
  assign push = inflight && !mispredict;
  assign pop  = valid_out && ready_out && !mispredict;

  // Control state: fetch PC, in-flight tracking, queue pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      head        <= '0;
      tail        <= '0;
      count_q     <= '0;
    end else if (mispredict) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count_q  <= '0;
    end else begin
      inflight    <= imem_req;
      inflight_pc <= fetch_pc;
      if (imem_req) fetch_pc <= fetch_pc + XLEN'(4);
      if (push)     tail     <= tail + AW'(1);
      if (pop)      head     <= head + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // Queue storage: write the returning response at the tail.
  // NOTE: storage is deliberately not reset; outputs are gated by valid_out so stale contents never escape.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      instr_mem[tail] <= imem_rdata;
      pc_mem[tail]    <= inflight_pc;
    end
  end

  assign count     = count_q;
  assign valid_out = (count_q != '0);
  assign instr_out = valid_out ? instr_mem[head] : 32'h0;
  assign pc_out    = valid_out ? pc_mem[head]    : '0;
  assign pc_4      = pc_out + XLEN'(4);

endmodule

// File: tb/tb_fetch_buf.sv
// tb_fetch_buf: scoreboard bench for fetch_buf. The reference model treats
// the backend's view as an unbroken stream of sequential PCs that restarts
// at the redirect target (or RESET_PC) after every flush.
module tb_fetch_buf;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        ready_out;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pc_4;
  logic [3:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_buf #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .mispredict(mispredict), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ready_out(ready_out), .valid_out(valid_out), .instr_out(instr_out),
    .pc_out(pc_out), .pc_4(pc_4), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Program image: the word at address a holds a + 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a + 32'h100;
  endfunction

  // Memory responder: data for a request appears exactly one cycle later; otherwise garbage.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= mem_word(imem_addr);
    else          imem_rdata <= $urandom();
  end

  // Reference model: expected stream of PCs the backend should receive.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  int          since_flush = 0;
  bit          started = 1'b0;

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  always @(posedge clk) begin
    if (reset || mispredict) begin
      exp_q.delete();
      gen_pc      = reset ? RESET_PC : redirect_pc;
      since_flush = 0;
      started     = 1'b1;
      refill();
    end else begin
      since_flush++;
    end
  end

  // Monitor: checks every pop and the stream/latency properties mid-cycle.
  always @(negedge clk) begin
    if (started) begin
      check("count_bound", 32'(count <= 4'(DEPTH)), 32'd1);
      if (reset || mispredict) check("req_blocked_by_flush", 32'(imem_req), 32'd0);
      if (since_flush < 2) check("empty_after_flush", 32'(valid_out), 32'd0);
      if (ready_out && !valid_out && since_flush >= 2)
        check("no_bubble", 32'(valid_out), 32'd1);
      if (valid_out) check("pc_4", pc_4, pc_out + 32'd4);
      if (valid_out && ready_out && !reset && !mispredict) begin
        logic [31:0] exp_pc;
        exp_pc = exp_q.pop_front();
        check("pop_pc", pc_out, exp_pc);
        check("pop_instr", instr_out, mem_word(exp_pc));
        refill();
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_head(input logic [31:0] pc, input int limit, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      if (valid_out && pc_out == pc) hit = 1'b1;
      else step();
    end
  endtask

  task automatic wait_count(input logic [3:0] n, input int limit, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit && !hit; i++) begin
      if (count == n) hit = 1'b1;
      else step();
    end
  endtask

  // Issue a one-cycle redirect from the current cycle.
  task automatic redirect(input logic [31:0] pc);
    mispredict  = 1'b1;
    redirect_pc = pc;
    step();
    mispredict  = 1'b0;
  endtask

  // Directed scenarios followed by a randomized phase.
  initial begin
    bit          hit;
    logic [31:0] r;
    reset = 1'b1; mispredict = 1'b0; redirect_pc = '0; ready_out = 1'b0;
    step(3);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_instr", instr_out, 32'd0);
    check("rst_pc", pc_out, 32'd0);
    check("rst_pc4", pc_4, 32'd4);

    // Linear fetch: request in the first cycle out of reset, data two cycles later.
    reset = 1'b0; ready_out = 1'b1;
    #1;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, RESET_PC);
    step(2);
    check("first_valid", 32'(valid_out), 32'd1);
    check("first_pc", pc_out, RESET_PC);
    step(10);

    // Backpressure: queue fills to DEPTH and requests stop.
    ready_out = 1'b0;
    step(20);
    check("bp_full", 32'(count), 32'(DEPTH));
    check("bp_no_req", 32'(imem_req), 32'd0);
    ready_out = 1'b1;
    step(30);

    // Mispredict while pc 0x8 is at the head.
    reset = 1'b1; step(); reset = 1'b0;
    wait_head(32'h8, 20, hit);
    check("reach_pc8", 32'(hit), 32'd1);
    redirect(32'h40);
    check("mp_count", 32'(count), 32'd0);
    check("mp_valid", 32'(valid_out), 32'd0);
    wait_head(32'h40, 5, hit);
    check("mp_target", 32'(hit), 32'd1);
    step(5);

    // Mispredict while full with a simultaneous pop.
    ready_out = 1'b0;
    wait_count(4'(DEPTH), 30, hit);
    check("reach_full", 32'(hit), 32'd1);
    ready_out = 1'b1;
    redirect(32'h200);
    check("full_mp_count", 32'(count), 32'd0);
    check("full_mp_valid", 32'(valid_out), 32'd0);
    step(10);

    // Mispredict held for several cycles: the last redirect wins.
    mispredict = 1'b1; redirect_pc = 32'h300; step();
    redirect_pc = 32'h380; step(2);
    mispredict = 1'b0;
    check("hold_count", 32'(count), 32'd0);
    wait_head(32'h380, 5, hit);
    check("hold_target", 32'(hit), 32'd1);

    // PC wrap.
    redirect(32'hFFFF_FFFC);
    wait_head(32'hFFFF_FFFC, 5, hit);
    check("wrap_head", 32'(hit), 32'd1);
    check("wrap_pc4", pc_4, 32'h0);
    step();
    check("wrap_next", pc_out, 32'h0);
    step(5);

    // Reset with five entries queued.
    ready_out = 1'b0;
    wait_count(4'd5, 30, hit);
    check("reach_5", 32'(hit), 32'd1);
    reset = 1'b1; step(); reset = 1'b0;
    check("rst5_count", 32'(count), 32'd0);
    check("rst5_valid", 32'(valid_out), 32'd0);
    ready_out = 1'b1;
    wait_head(RESET_PC, 5, hit);
    check("rst5_restart", 32'(hit), 32'd1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ready_out  = ($urandom_range(0, 3) != 0);
      mispredict = ($urandom_range(0, 39) == 0);
      r = $urandom();
      r[1:0] = 2'b00;
      redirect_pc = r;
      reset = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0; mispredict = 1'b0; ready_out = 1'b1;
    step(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
